ps2_host_tx: RTL and testbench



---
 rtl/ps2_pkg.sv | 32 +++
 rtl/ps2_sync.sv | 37 +++
 rtl/ps2_host_tx.sv | 216 +++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit state encoding, keyboard command
// bytes and cycle-count helpers. Used by the host transmitter and shareable
// with the keyboard receiver.
package ps2_pkg;

  // Host-to-device transmit states
  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SEND,
    ACK,
    WAITIDLE
  } ps2_tx_state_t;

  // Common keyboard command bytes and the device acknowledge code
  localparam logic [7:0] PS2_CMD_LED    = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET  = 8'hFF;
  localparam logic [7:0] PS2_CMD_ENABLE = 8'hF4;
  localparam logic [7:0] PS2_ACK        = 8'hFA;

  // Number of system clock cycles in 'us' microseconds at 'khz' kHz
  function automatic int unsigned cycles(input int unsigned khz, input int unsigned us);
    return (khz * us) / 1000;
  endfunction

  // PS/2 frames carry odd parity: parity bit makes the total count of ones odd
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_sync.sv
// Two-flop synchronizer for a raw PS/2 line plus falling-edge detector.
// Idle PS/2 lines float high, so every flop resets to 1 to avoid a phantom
// falling edge right after reset.
//
// Ports:
//   clk     system clock
//   reset   synchronous, active-high
//   din     raw asynchronous line level
//   level   synchronized line level (registered)
//   fall_c  combinational one-cycle strobe: previous level 1, current level 0
module ps2_sync (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic fall_c
);

  logic meta;
  logic prev;

  // Metastability flop, synchronized level, and one-cycle history for edges
  always_ff @(posedge clk) begin
    if (reset) begin
      meta  <= 1'b1;
      level <= 1'b1;
      prev  <= 1'b1;
    end else begin
      meta  <= din;
      level <= meta;
      prev  <= level;
    end
  end

  assign fall_c = prev & ~level;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter. Accepts one command byte at a time,
// inhibits the bus, issues a request-to-send, shifts the byte out LSB first
// on device clock falling edges followed by odd parity and stop, then checks
// the device ACK. Lines are driven open-drain through the *_oe outputs
// (1 = pull low).
//
// Ports:
//   clk, reset              system clock, synchronous active-high reset
//   tx_data, tx_valid       command byte and send request
//   tx_ready                high only while idle; byte accepted on valid & ready
//   ps2_clk_i, ps2_dat_i    raw asynchronous line levels
//   ps2_clk_oe, ps2_dat_oe  pull-low enables for the clock and data lines
//   busy                    high whenever a command is in flight
//   done                    one-cycle pulse: ACK received and bus back to idle
//   error                   one-cycle pulse: missing ACK or timeout
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_KHZ    = 12000,
  parameter int unsigned INHIBIT_US = 120,
  parameter int unsigned TIMEOUT_MS = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int unsigned INHIBIT_CYC = cycles(CLK_KHZ, INHIBIT_US);
  localparam int unsigned TIMEOUT_CYC = CLK_KHZ * TIMEOUT_MS;
  localparam int unsigned INH_W       = $clog2(INHIBIT_CYC + 1);
  localparam int unsigned TO_W        = $clog2(TIMEOUT_CYC + 1);

  // Synchronized line levels and clock falling edge
  logic clk_level;
  logic clk_fall;
  logic dat_level;
  logic dat_fall_unused;

  ps2_sync u_sync_clk (
    .clk    (clk),
    .reset  (reset),
    .din    (ps2_clk_i),
    .level  (clk_level),
    .fall_c (clk_fall)
  );

  ps2_sync u_sync_dat (
    .clk    (clk),
    .reset  (reset),
    .din    (ps2_dat_i),
    .level  (dat_level),
    .fall_c (dat_fall_unused)
  );

  // Current-cycle registers
  ps2_tx_state_t    state;
  logic [7:0]       shreg;
  logic             parity;
  logic [3:0]       bitcnt;
  logic [INH_W-1:0] inh_cnt;
  logic [TO_W-1:0]  to_cnt;

  // Next-cycle values
  ps2_tx_state_t    state_n;
  logic [7:0]       shreg_n;
  logic             parity_n;
  logic [3:0]       bitcnt_n;
  logic [3:0]       bit_nxt;
  logic [INH_W-1:0] inh_n;
  logic [TO_W-1:0]  to_n;
  logic             clk_oe_n;
  logic             dat_oe_n;
  logic             busy_n;
  logic             ready_n;
  logic             done_n;
  logic             error_n;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      shreg      <= '0;
      parity     <= 1'b0;
      bitcnt     <= '0;
      inh_cnt    <= '0;
      to_cnt     <= '0;
      ps2_clk_oe <= 1'b0;
      ps2_dat_oe <= 1'b0;
      busy       <= 1'b0;
      tx_ready   <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      state      <= state_n;
      shreg      <= shreg_n;
      parity     <= parity_n;
      bitcnt     <= bitcnt_n;
      inh_cnt    <= inh_n;
      to_cnt     <= to_n;
      ps2_clk_oe <= clk_oe_n;
      ps2_dat_oe <= dat_oe_n;
      busy       <= busy_n;
      tx_ready   <= ready_n;
      done       <= done_n;
      error      <= error_n;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_n  = state;
    shreg_n  = shreg;
    parity_n = parity;
    bitcnt_n = bitcnt;
    inh_n    = inh_cnt;
    to_n     = to_cnt;
    dat_oe_n = ps2_dat_oe;
    done_n   = 1'b0;
    error_n  = 1'b0;
    bit_nxt  = bitcnt + 4'd1;

    unique case (state)
      IDLE: begin
        dat_oe_n = 1'b0;
        if (tx_valid && tx_ready) begin
          shreg_n  = tx_data;
          parity_n = odd_parity(tx_data);
          inh_n    = '0;
          state_n  = INHIBIT;
        end
      end

      INHIBIT: begin
        if (inh_cnt == INH_W'(INHIBIT_CYC - 1)) begin
          dat_oe_n = 1'b1;
          state_n  = REQ;
        end else begin
          inh_n = inh_cnt + INH_W'(1);
        end
      end

      // Start bit: data held low while the clock is released in SEND
      REQ: begin
        dat_oe_n = 1'b1;
        bitcnt_n = '0;
        to_n     = '0;
        state_n  = SEND;
      end

      // Data changes on device falling edges; the device samples while high
      SEND: begin
        to_n = to_cnt + TO_W'(1);
        if (clk_fall) begin
          bitcnt_n = bit_nxt;
          if (bit_nxt <= 4'd8) begin
            dat_oe_n = ~shreg[0];
            shreg_n  = {1'b0, shreg[7:1]};
          end else if (bit_nxt == 4'd9) begin
            dat_oe_n = ~parity;
          end else begin
            dat_oe_n = 1'b0;
            state_n  = ACK;
          end
        end
      end

      ACK: begin
        to_n = to_cnt + TO_W'(1);
        if (clk_fall) begin
          if (!dat_level) begin
            state_n = WAITIDLE;
          end else begin
            error_n = 1'b1;
            state_n = IDLE;
          end
        end
      end

      WAITIDLE: begin
        to_n = to_cnt + TO_W'(1);
        if (clk_level && dat_level) begin
          done_n  = 1'b1;
          state_n = IDLE;
        end
      end

      default: state_n = IDLE;
    endcase

    // Timeout overrides whatever the device is doing; error beats done
    if ((state == SEND || state == ACK || state == WAITIDLE) &&
        to_n == TO_W'(TIMEOUT_CYC)) begin
      error_n = 1'b1;
      done_n  = 1'b0;
      state_n = IDLE;
    end

    if (state_n == IDLE) begin
      dat_oe_n = 1'b0;
    end

    clk_oe_n = (state_n == INHIBIT) || (state_n == REQ);
    busy_n   = (state_n != IDLE);
    ready_n  = (state_n == IDLE);
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: a keyboard device model clocks frames
// out of the host, samples bits while its clock is high and answers with
// ACK, NACK or silence. Expected frames are built from the byte with plain
// arithmetic; a per-cycle monitor checks handshake, pulse and inhibit rules.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int unsigned CLK_KHZ    = 100;
  localparam int unsigned INHIBIT_US = 200;
  localparam int unsigned TIMEOUT_MS = 15;
  localparam int unsigned INH_CYC    = CLK_KHZ * INHIBIT_US / 1000;
  localparam int unsigned TO_CYC     = CLK_KHZ * TIMEOUT_MS;
  localparam int          BOUND      = int'(INH_CYC + TO_CYC + 400);

  localparam int DEV_ACK  = 0;
  localparam int DEV_NACK = 1;
  localparam int DEV_MUTE = 2;

  logic       clk      = 1'b0;
  logic       reset    = 1'b1;
  logic [7:0] tx_data  = 8'h00;
  logic       tx_valid = 1'b0;
  logic       dev_clk  = 1'b1;
  logic       dev_dat  = 1'b1;
  logic       clk_line;
  logic       dat_line;
  logic       tx_ready;
  logic       ps2_clk_oe;
  logic       ps2_dat_oe;
  logic       busy;
  logic       done;
  logic       error;

  int checks   = 0;
  int errors   = 0;
  int cyc      = 0;
  int exp_done = 0;
  int exp_err  = 0;

  assign clk_line = dev_clk & ~ps2_clk_oe;
  assign dat_line = dev_dat & ~ps2_dat_oe;

  ps2_host_tx #(
    .CLK_KHZ    (CLK_KHZ),
    .INHIBIT_US (INHIBIT_US),
    .TIMEOUT_MS (TIMEOUT_MS)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .ps2_clk_i  (clk_line),
    .ps2_dat_i  (dat_line),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Odd parity from the count of ones
  function automatic logic model_par(input logic [7:0] b);
    return ($countones(b) % 2) == 0;
  endfunction

  // Per-cycle monitor, sampled mid-low-phase after stimulus has settled
  logic done_q = 1'b0, err_q = 1'b0, clk_oe_q = 1'b0, acc_q = 1'b0;
  int   run = 0, entry_cyc = 0, err_cyc = 0, done_cnt = 0, err_cnt = 0;

  always @(negedge clk) begin
    #1;
    if (reset) begin
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      clk_oe_q <= 1'b0;
      acc_q    <= 1'b0;
      run      <= 0;
    end else begin
      chk("ready_vs_busy", int'(tx_ready), int'(!busy));
      if (!busy) chk("idle_oe", int'({ps2_clk_oe, ps2_dat_oe}), 0);
      chk("done_error_excl", int'(done & error), 0);
      if (done_q) chk("done_width", int'(done), 0);
      if (err_q)  chk("error_width", int'(error), 0);
      if (ps2_clk_oe && !clk_oe_q) chk("clk_oe_after_accept", int'(acc_q), 1);
      if (!ps2_clk_oe && clk_oe_q) begin
        chk("inhibit_len", run, int'(INH_CYC + 1));
        entry_cyc <= cyc;
      end
      if (error && !err_q) err_cyc <= cyc;
      if (done)  done_cnt <= done_cnt + 1;
      if (error) err_cnt  <= err_cnt + 1;
      done_q   <= done;
      err_q    <= error;
      clk_oe_q <= ps2_clk_oe;
      acc_q    <= tx_valid & tx_ready;
      run      <= ps2_clk_oe ? run + 1 : 0;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int w;
    @(negedge clk);
    tx_data  = b;
    tx_valid = 1'b1;
    w = 0;
    while (!tx_ready && w < BOUND) begin
      @(negedge clk);
      w++;
    end
    if (!tx_ready) chk("send_ready_wait", 0, 1);
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Keyboard model: waits for the request-to-send, then clocks 11 edges.
  task automatic dev_xfer(input logic [7:0] b, input int mode, input int h,
                          input int abort_fall, output logic [9:0] got);
    logic [9:0] frame;
    int w;
    got   = '0;
    frame = {1'b1, model_par(b), b};
    w = 0;
    while (!ps2_clk_oe && w < 400) begin
      @(negedge clk);
      w++;
    end
    if (!ps2_clk_oe) begin
      chk("dev_wait_inhibit", 0, 1);
      return;
    end
    w = 0;
    while (ps2_clk_oe && w < int'(INH_CYC) + 20) begin
      @(negedge clk);
      w++;
    end
    if (ps2_clk_oe) begin
      chk("dev_wait_release", 0, 1);
      return;
    end
    chk("start_bit", int'(dat_line), 0);
    if (mode == DEV_MUTE) return;
    repeat (h) @(negedge clk);
    for (int n = 1; n <= 11; n++) begin
      dev_clk = 1'b0;
      repeat (3) @(negedge clk);
      if (n <= 10) chk($sformatf("dat_oe_fall%0d", n), int'(ps2_dat_oe), int'(!frame[n-1]));
      if (n == abort_fall) begin
        dev_clk = 1'b1;
        return;
      end
      repeat (h - 3) @(negedge clk);
      dev_clk = 1'b1;
      repeat (h / 2) @(negedge clk);
      if (n <= 10) got[n-1] = dat_line;
      if (n == 10 && mode == DEV_ACK) dev_dat = 1'b0;
      repeat (h - h / 2) @(negedge clk);
    end
    dev_dat = 1'b1;
  endtask

  task automatic wait_outcome(input bit exp_done_pulse, output int at_cyc);
    int n;
    n = 0;
    @(negedge clk);
    while (!(done || error) && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    at_cyc = cyc;
    if (!(done || error)) begin
      chk("outcome_wait", 0, 1);
      return;
    end
    chk("outcome_done", int'(done), int'(exp_done_pulse));
    chk("outcome_error", int'(error), int'(!exp_done_pulse));
    chk("outcome_idle", int'(busy), 0);
  endtask

  task automatic xfer(input logic [7:0] b, input int mode, input int h, input int par_lit);
    logic [9:0] got;
    int at;
    fork
      send_byte(b);
      dev_xfer(b, mode, h, 0, got);
      wait_outcome(mode == DEV_ACK, at);
    join
    if (mode == DEV_ACK) exp_done++;
    else exp_err++;
    if (mode != DEV_MUTE) begin
      chk($sformatf("data_%02h", b), int'(got[7:0]), int'(b));
      chk($sformatf("parity_%02h", b), int'(got[8]), int'(model_par(b)));
      chk($sformatf("stop_%02h", b), int'(got[9]), 1);
      if (par_lit >= 0) chk($sformatf("parity_lit_%02h", b), int'(got[8]), par_lit);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    logic [9:0] g1, g2;
    int acc2, dcyc, ecyc, w;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_clk_oe", int'(ps2_clk_oe), 0);
    chk("rst_dat_oe", int'(ps2_dat_oe), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_error", int'(error), 0);
    chk("rst_ready", int'(tx_ready), 1);

    // LED command (bits 1,0,1,1,0,1,1,1, parity 1) and enable (parity 0)
    xfer(PS2_CMD_LED, DEV_ACK, 8, 1);
    xfer(PS2_CMD_ENABLE, DEV_ACK, 10, 0);

    // Device leaves data high at the ACK edge
    xfer(PS2_CMD_LED, DEV_NACK, 7, 1);
    @(negedge clk);
    chk("nack_lines", int'({ps2_clk_oe, ps2_dat_oe}), 0);

    // Device never clocks: timeout measured from clock release
    xfer(PS2_CMD_ENABLE, DEV_MUTE, 8, -1);
    @(negedge clk);
    chk("timeout_cycles", err_cyc - entry_cyc, int'(TO_CYC));
    chk("timeout_ready", int'(tx_ready), 1);
    chk("timeout_lines", int'({ps2_clk_oe, ps2_dat_oe}), 0);

    // Reset in the middle of a reset-command frame, then a clean 0x00
    fork
      send_byte(PS2_CMD_RESET);
      dev_xfer(PS2_CMD_RESET, DEV_ACK, 8, 5, g1);
    join
    chk("pre_reset_busy", int'(busy), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_clk_oe", int'(ps2_clk_oe), 0);
    chk("mid_rst_dat_oe", int'(ps2_dat_oe), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_ready", int'(tx_ready), 1);
    repeat (4) @(negedge clk);
    xfer(8'h00, DEV_ACK, 6, 1);

    // tx_valid held high across two bytes: second accepted only after done
    fork
      begin
        @(negedge clk);
        tx_data  = PS2_CMD_LED;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_data = 8'h02;
        w = 0;
        while (!tx_ready && w < BOUND) begin
          @(negedge clk);
          w++;
        end
        acc2 = cyc;
        @(negedge clk);
        tx_valid = 1'b0;
      end
      begin
        dev_xfer(PS2_CMD_LED, DEV_ACK, 7, 0, g1);
        dev_xfer(8'h02, DEV_ACK, 9, 0, g2);
      end
      begin
        wait_outcome(1'b1, dcyc);
        wait_outcome(1'b1, ecyc);
      end
    join
    exp_done += 2;
    chk("held_accept_at_done", acc2 - dcyc, 0);
    chk("held_first_byte", int'(g1[7:0]), 32'hED);
    chk("held_first_parity", int'(g1[8]), 1);
    chk("held_second_byte", int'(g2[7:0]), 32'h02);
    chk("held_second_parity", int'(g2[8]), 0);
    chk("held_second_stop", int'(g2[9]), 1);

    // Randomized bytes, device clock rates and ACK/NACK responses
    for (int i = 0; i < 8; i++) begin
      logic [7:0] b;
      int mode;
      int h;
      b    = 8'($urandom);
      mode = int'($urandom_range(0, 1));
      h    = int'($urandom_range(6, 12));
      repeat (int'($urandom_range(1, 5))) @(negedge clk);
      xfer(b, mode, h, -1);
    end

    repeat (3) @(negedge clk);
    chk("total_done", done_cnt, exp_done);
    chk("total_error", err_cnt, exp_err);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
